// File: rtl/dynamic_routing_wsum_acc.sv
// rtl/dynamic_routing_wsum_acc.sv - weighted-sum accumulator for the dynamic-routing digit-caps stage
// Multiplies coef x pred per term, sums NUM_TERMS products, then rounds, shifts and saturates.
module dynamic_routing_wsum_acc #(
  parameter int COEF_W     = 12,
  parameter int PRED_W     = 14,
  parameter int PROD_W     = COEF_W + PRED_W,
  parameter int NUM_TERMS  = 1152,
  parameter int ACC_W      = PROD_W + $clog2(NUM_TERMS),
  parameter int FRAC_SHIFT = 12,
  parameter int OUT_W      = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [COEF_W-1:0] coef,
  input  logic [PRED_W-1:0] pred,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OUT_W-1:0]  s_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(NUM_TERMS);
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);
  localparam logic [ACC_W:0] MAXV = (ACC_W + 1)'({OUT_W{1'b1}});

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

  state_t             state, state_nxt;
  logic [PROD_W-1:0]  p_reg;
  logic               p_vld;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_term;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W:0]     r;

  assign accept    = in_valid & in_ready;
  assign last_term = (cnt == CNT_W'(NUM_TERMS - 1));
  assign acc_sum   = p_vld ? acc + ACC_W'(p_reg) : acc;
  // Extra top bit keeps the rounding add from wrapping when acc is near full scale.
  assign r         = ({1'b0, acc_sum} + HALF) >> FRAC_SHIFT;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= S_ACC;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept && last_term) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_ACC);
    out_valid = (state == S_OUT);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      p_reg     <= '0;
      p_vld     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      s_out     <= '0;
      frame_err <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_reg <= PROD_W'(coef) * PROD_W'(pred);
        cnt   <= last_term ? '0 : cnt + CNT_W'(1);
        // The count closes the sum; in_last only flags disagreement.
        if (in_last != last_term) frame_err <= 1'b1;
      end
      if (state == S_OUT && out_ready) acc <= '0;
      else                             acc <= acc_sum;
      if (state == S_DRAIN) s_out <= (r > MAXV) ? '1 : r[OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_dynamic_routing_wsum_acc.sv
// tb/tb_dynamic_routing_wsum_acc.sv - self-checking bench for dynamic_routing_wsum_acc
// Spec-level model plus directed vectors; a second instance covers the 8-term saturating case.
module tb_dynamic_routing_wsum_acc;
  localparam int N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [11:0] coef = '0;
  logic [13:0] pred = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic        in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready, out_valid, frame_err;
  logic        in_ready8, out_valid8, frame_err8;
  logic [15:0] s_out, s_out8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 ap_clk = ~ap_clk;

  dynamic_routing_wsum_acc #(.NUM_TERMS(N)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .coef(coef), .pred(pred),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .s_out(s_out), .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );

  dynamic_routing_wsum_acc #(.NUM_TERMS(8)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .coef(coef), .pred(pred),
    .in_valid(in_valid8), .in_last(in_last8), .in_ready(in_ready8),
    .s_out(s_out8), .out_valid(out_valid8), .out_ready(out_ready8), .frame_err(frame_err8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a sum is the list of accepted terms; its result is round-half-up then clamp.
  function automatic longint round_sat(input longint s);
    longint r;
    r = (s + 2048) >>> 12;
    return (r > 65535) ? 65535 : r;
  endfunction

  int     m_cnt, m_phase;
  longint m_sum, m_pending, m_exp_sout;
  bit     m_ferr;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_cnt = 0; m_sum = 0; m_phase = 0; m_exp_sout = 0; m_ferr = 0; m_pending = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_sum += longint'(coef) * longint'(pred);
          m_cnt++;
          if (in_last != (m_cnt == N)) m_ferr = 1;
          if (m_cnt == N) begin
            m_pending = round_sat(m_sum);
            m_cnt = 0; m_sum = 0; m_phase = 1;
          end
        end
        1: begin m_exp_sout = m_pending; m_phase = 2; end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      check("cmp_in_ready", in_ready, m_phase == 0);
      check("cmp_out_valid", out_valid, m_phase == 2);
      check("cmp_s_out", s_out, m_exp_sout);
      check("cmp_frame_err", frame_err, m_ferr);
    end
  end

  task automatic send(input int c, input int p, input bit last);
    int n;
    coef = 12'(c); pred = 14'(p); in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge ap_clk); n++; end
    if (n == 50) check("send_timeout", 0, 1);
    @(negedge ap_clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_out(output logic [15:0] v, output int w);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge ap_clk); w++; end
    if (!out_valid) check("out_timeout", 0, 1);
    v = s_out;
    @(negedge ap_clk);
  endtask

  task automatic sum4(input int c, input int p, output logic [15:0] v);
    int w;
    for (int i = 0; i < N; i++) send(c, p, i == N - 1);
    get_out(v, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int w;

    // Reset held with in_valid high: nothing may be accepted.
    in_valid = 1'b1; coef = 12'd7; pred = 14'd9;
    @(negedge ap_clk);
    chk_en = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s_out", s_out, 0);
    check("rst_frame_err", frame_err, 0);
    in_valid = 1'b0; ap_rst_n = 1'b1;

    // Basic sum with latency and in_ready during DRAIN/OUT.
    for (int i = 0; i < N; i++) send(4095, 100, i == N - 1);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    get_out(v, w);
    check("basic_latency", w, 1);
    check("basic_s_out", v, 400);

    // Round half up.
    send(1, 2048, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 1);
    get_out(v, w);
    check("round_up", v, 1);
    send(1, 2047, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 1);
    get_out(v, w);
    check("round_down", v, 0);

    // Full-scale terms.
    sum4(4095, 16383, v);
    check("fullscale4", v, 65516);
    coef = 12'd4095; pred = 14'd16383;
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'b1; in_last8 = (i == 7);
      check("dut8_in_ready", in_ready8, 1);
      @(negedge ap_clk);
    end
    in_valid8 = 1'b0; in_last8 = 1'b0;
    w = 0;
    while (!out_valid8 && w < 20) begin @(negedge ap_clk); w++; end
    check("dut8_sat", s_out8, 65535);
    check("dut8_frame_err", frame_err8, 0);
    @(negedge ap_clk);

    // Random gaps between terms.
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge ap_clk);
      send(4095, 100, i == N - 1);
    end
    get_out(v, w);
    check("gaps_s_out", v, 400);

    // Back-pressure: output held, no term accepted.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(4095, 100, i == N - 1);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge ap_clk); w++; end
    in_valid = 1'b1; coef = 12'd5; pred = 14'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      check("bp_hold", s_out, 400);
      check("bp_out_valid", out_valid, 1);
      check("bp_no_accept", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge ap_clk);
    sum4(4095, 4095, v);
    check("fresh_after_bp", v, 16376);
    check("no_frame_err_yet", frame_err, 0);

    // Misplaced in_last: error flagged, sum still closes on the count.
    send(100, 100, 0); send(100, 100, 1); send(100, 100, 0); send(100, 100, 1);
    get_out(v, w);
    check("frame_s_out", v, 10);
    check("frame_err_set", frame_err, 1);

    // Mid-sum reset discards partial accumulation.
    send(4095, 16383, 0); send(4095, 16383, 0);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    check("reset_clears_ferr", frame_err, 0);
    sum4(4095, 100, v);
    check("post_reset_sum", v, 400);

    repeat (2) @(negedge ap_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
